// File: rtl/screen_scanner.sv
// 640x480 VGA scanner with a two-stage character-tile fetch pipeline.
// Optional frame_pulse output: define SCREEN_SCANNER_FRAME_PULSE_EN.
module screen_scanner #(
    parameter int PIX_DIV = 4,
    parameter int COLS    = 40,
    parameter int ROWS    = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [10:0] screen_addr,
    input  logic [3:0]  character_code,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [3:0]  char_out,
    output logic [3:0]  xoff,
    output logic [3:0]  yoff
`ifdef SCREEN_SCANNER_FRAME_PULSE_EN
    ,
    output logic        frame_pulse
`endif
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [9:0] H_VIS   = 10'd640;
    localparam logic [9:0] H_SYNC0 = 10'd656;
    localparam logic [9:0] H_SYNC1 = 10'd751;
    localparam logic [9:0] H_LAST  = 10'd799;
    localparam logic [9:0] V_VIS   = 10'd480;
    localparam logic [9:0] V_SYNC0 = 10'd490;
    localparam logic [9:0] V_SYNC1 = 10'd491;
    localparam logic [9:0] V_LAST  = 10'd524;

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [9:0]       hcount;
    logic [9:0]       vcount;
    logic             h_end;
    logic             v_end;

    logic             vis_c;
    logic             grid_c;
    logic             hs_c;
    logic             vs_c;
    logic [10:0]      addr_c;

    logic             s1_hs;
    logic             s1_vs;
    logic             s1_act;
    logic [3:0]       s1_xoff;
    logic [3:0]       s1_yoff;

    assign tick  = (div == DIV_W'(PIX_DIV - 1));
    assign h_end = (hcount == H_LAST);
    assign v_end = (vcount == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (tick) begin
            if (h_end) begin
                hcount <= '0;
                vcount <= v_end ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end
    end

    // Grid bound keeps the address inside COLS*ROWS for smaller screens
    always_comb begin
        vis_c  = (hcount < H_VIS) && (vcount < V_VIS);
        grid_c = (32'(hcount[9:4]) < COLS) && (32'(vcount[9:4]) < ROWS);
        hs_c   = !((hcount >= H_SYNC0) && (hcount <= H_SYNC1));
        vs_c   = !((vcount >= V_SYNC0) && (vcount <= V_SYNC1));
        addr_c = '0;
        if (vis_c && grid_c) begin
            addr_c = 11'(vcount[9:4]) * 11'(COLS) + 11'(hcount[9:4]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            screen_addr <= '0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s1_act      <= 1'b0;
            s1_xoff     <= '0;
            s1_yoff     <= '0;
        end else if (tick) begin
            screen_addr <= addr_c;
            s1_hs       <= hs_c;
            s1_vs       <= vs_c;
            s1_act      <= vis_c;
            s1_xoff     <= hcount[3:0];
            s1_yoff     <= vcount[3:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            active   <= 1'b0;
            char_out <= '0;
            xoff     <= '0;
            yoff     <= '0;
        end else if (tick) begin
            hsync    <= s1_hs;
            vsync    <= s1_vs;
            active   <= s1_act;
            char_out <= s1_act ? character_code : 4'd0;
            xoff     <= s1_xoff;
            yoff     <= s1_yoff;
        end
    end

`ifdef SCREEN_SCANNER_FRAME_PULSE_EN
    // High for the single clk after the tick that enters vertical blank
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_pulse <= 1'b0;
        end else begin
            frame_pulse <= tick && h_end && (vcount == V_VIS - 10'd1);
        end
    end
`endif

endmodule

// File: tb/tb_screen_scanner.sv
// Directed, table-driven bench for screen_scanner (PIX_DIV=4).
// Counter positions are preset between ticks to reach far-off corners quickly.
module tb_screen_scanner;

    logic        clk;
    logic        reset_n;
    logic [10:0] screen_addr;
    logic [3:0]  character_code;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [3:0]  char_out;
    logic [3:0]  xoff;
    logic [3:0]  yoff;
`ifdef SCREEN_SCANNER_FRAME_PULSE_EN
    logic        frame_pulse;
`endif

    int checks;
    int failures;
    logic [9:0] fh;
    logic [9:0] fv;

    screen_scanner dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .screen_addr    (screen_addr),
        .character_code (character_code),
        .hsync          (hsync),
        .vsync          (vsync),
        .active         (active),
        .char_out       (char_out),
        .xoff           (xoff),
        .yoff           (yoff)
`ifdef SCREEN_SCANNER_FRAME_PULSE_EN
        ,
        .frame_pulse    (frame_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          h;
        int          v;
        logic [3:0]  code;
        logic [10:0] addr;
        logic        act;
        logic        hs;
        logic        vs;
        logic [3:0]  ch;
        logic [3:0]  xo;
        logic [3:0]  yo;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Four clks per tick; returns 1 time unit after the tick edge
    task automatic tick_wait();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic place(input int h, input int v);
        fh = 10'(h);
        fv = 10'(v);
        force dut.hcount = fh;
        force dut.vcount = fv;
        #1;
        release dut.hcount;
        release dut.vcount;
    endtask

    initial begin
        int lows;
        logic [31:0] snap;
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        character_code = 4'h0;

        vt[0]  = '{35, 18, 4'hA, 11'd42, 1, 1, 1, 4'hA, 4'd3, 4'd2};
        vt[1]  = '{0, 0, 4'h5, 11'd0, 1, 1, 1, 4'h5, 4'd0, 4'd0};
        vt[2]  = '{639, 479, 4'h7, 11'd1199, 1, 1, 1, 4'h7, 4'd15, 4'd15};
        vt[3]  = '{640, 479, 4'h7, 11'd0, 0, 1, 1, 4'h0, 4'd0, 4'd15};
        vt[4]  = '{656, 100, 4'h3, 11'd0, 0, 0, 1, 4'h0, 4'd0, 4'd4};
        vt[5]  = '{751, 100, 4'h3, 11'd0, 0, 0, 1, 4'h0, 4'd15, 4'd4};
        vt[6]  = '{752, 100, 4'h3, 11'd0, 0, 1, 1, 4'h0, 4'd0, 4'd4};
        vt[7]  = '{655, 100, 4'h3, 11'd0, 0, 1, 1, 4'h0, 4'd15, 4'd4};
        vt[8]  = '{100, 490, 4'h9, 11'd0, 0, 1, 0, 4'h0, 4'd4, 4'd10};
        vt[9]  = '{100, 491, 4'h9, 11'd0, 0, 1, 0, 4'h0, 4'd4, 4'd11};
        vt[10] = '{100, 489, 4'h9, 11'd0, 0, 1, 1, 4'h0, 4'd4, 4'd9};
        vt[11] = '{100, 492, 4'h9, 11'd0, 0, 1, 1, 4'h0, 4'd4, 4'd12};
        vt[12] = '{320, 240, 4'hC, 11'd620, 1, 1, 1, 4'hC, 4'd0, 4'd0};
        vt[13] = '{799, 524, 4'h1, 11'd0, 0, 1, 1, 4'h0, 4'd15, 4'd12};

        #23;
        chk("rst_addr", int'(screen_addr), 0);
        chk("rst_char", int'(char_out), 0);
        chk("rst_xoff", int'(xoff), 0);
        chk("rst_yoff", int'(yoff), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);

        @(negedge clk);
        reset_n = 1'b1;
        character_code = 4'h6;
        tick_wait();
        chk("start_addr", int'(screen_addr), 0);
        tick_wait();
        chk("start_active", int'(active), 1);
        chk("start_char", int'(char_out), 6);
        repeat (15) tick_wait();
        chk("start_addr16", int'(screen_addr), 1);
        chk("start_xoff15", int'(xoff), 15);

        for (int i = 0; i < 14; i++) begin
            character_code = vt[i].code;
            place(vt[i].h, vt[i].v);
            tick_wait();
            chk($sformatf("v%0d_addr", i), int'(screen_addr), int'(vt[i].addr));
            tick_wait();
            chk($sformatf("v%0d_active", i), int'(active), int'(vt[i].act));
            chk($sformatf("v%0d_hsync", i), int'(hsync), int'(vt[i].hs));
            chk($sformatf("v%0d_vsync", i), int'(vsync), int'(vt[i].vs));
            chk($sformatf("v%0d_char", i), int'(char_out), int'(vt[i].ch));
            chk($sformatf("v%0d_xoff", i), int'(xoff), int'(vt[i].xo));
            chk($sformatf("v%0d_yoff", i), int'(yoff), int'(vt[i].yo));
        end

        // Line wrap bumps the row; frame wrap returns to (0,0)
        character_code = 4'h2;
        place(799, 17);
        tick_wait();
        tick_wait();
        chk("hwrap_addr", int'(screen_addr), 40);
        tick_wait();
        chk("hwrap_active", int'(active), 1);
        chk("hwrap_yoff", int'(yoff), 2);
        chk("hwrap_xoff", int'(xoff), 0);
        place(799, 524);
        tick_wait();
        tick_wait();
        tick_wait();
        chk("fwrap_active", int'(active), 1);
        chk("fwrap_yoff", int'(yoff), 0);
        chk("fwrap_char", int'(char_out), 2);

        snap = {16'(screen_addr), xoff, yoff, char_out, hsync, vsync, active, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        chk("stable", int'({16'(screen_addr), xoff, yoff, char_out, hsync, vsync, active, 1'b0}), int'(snap));

        place(600, 5);
        tick_wait();
        tick_wait();
        lows = 0;
        for (int i = 0; i < 800; i++) begin
            if (!hsync) lows++;
            tick_wait();
        end
        chk("hsync_low_ticks", lows, 96);

        place(799, 488);
        tick_wait();
        tick_wait();
        lows = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!vsync) lows++;
            tick_wait();
        end
        chk("vsync_low_ticks", lows, 1600);

`ifdef SCREEN_SCANNER_FRAME_PULSE_EN
        place(790, 479);
        lows = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (frame_pulse) lows++;
        end
        chk("frame_pulse_count", lows, 1);
`endif

        place(300, 200);
        character_code = 4'hB;
        tick_wait();
        tick_wait();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", int'(screen_addr), 0);
        chk("mid_rst_active", int'(active), 0);
        chk("mid_rst_char", int'(char_out), 0);
        chk("mid_rst_xoff", int'(xoff), 0);
        chk("mid_rst_yoff", int'(yoff), 0);
        chk("mid_rst_hsync", int'(hsync), 1);
        chk("mid_rst_vsync", int'(vsync), 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick_wait();
        chk("rel_addr", int'(screen_addr), 0);
        tick_wait();
        chk("rel_active", int'(active), 1);
        chk("rel_xoff", int'(xoff), 0);
        chk("rel_yoff", int'(yoff), 0);
        chk("rel_char", int'(char_out), 11);
        repeat (15) tick_wait();
        chk("rel_addr16", int'(screen_addr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
